fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the five-stage RV32I core. It owns the PC, issues in-order requests to a variable-latency instruction memory, and buffers responses in a small prefetch queue. It delivers one instruction per cycle to decode and follows the stall, flush and redirect controls generated by the hazard unit and the execute stage.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_stage.sv | 166 ++++++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // Canonical RV32I bubble: addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    // PC the core starts fetching from when no override is given
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One prefetch-queue slot: the instruction and the PC it was fetched from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fall-through prefetch queue. When empty, a pushed entry is visible at the
// head in the same cycle, and if it is also popped it never gets stored.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  fetch_entry_t  i_push_data,
    input  logic          i_pop,
    input  logic          i_clear,
    output logic [CW-1:0] o_count,
    output logic          o_head_valid,
    output fetch_entry_t  o_head_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [2**PW];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_bypass;
    logic w_wr;
    logic w_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_empty      = (r_count == '0);
    assign w_bypass     = w_empty & i_push & i_pop;
    assign w_wr         = i_push & ~w_bypass & ~i_clear;
    assign w_rd         = i_pop & ~w_empty;
    assign o_count      = r_count;
    assign o_head_valid = ~w_empty | i_push;
    assign o_head_data  = w_empty ? i_push_data : r_mem[r_rd];

    // Pointer and occupancy bookkeeping; clear empties the queue in one cycle
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wr <= ptr_inc(r_wr);
            if (w_rd) r_rd <= ptr_inc(r_rd);
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= i_push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with prefetch queue and IF/ID register.
// Optional feature macro: FETCH_PREFETCH_EN -- when defined the queue holds
// FIFO_DEPTH entries with as many requests in flight; otherwise one entry and
// a single outstanding request.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReqValid,
    input  logic            ImemReqReady,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemRspValid,
    input  logic [31:0]     ImemRspData,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = FIFO_DEPTH;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (FIFO_DEPTH < 2) begin : g_depth_check
        $error("FIFO_DEPTH must be at least 2");
    end

    logic [XLEN-1:0] r_pcf;
    logic [CW-1:0]   r_out;
    logic [CW-1:0]   r_drop;
    logic [XLEN-1:0] r_shadow [2**PW];
    logic [PW-1:0]   r_sh_wr;
    logic [PW-1:0]   r_sh_rd;

    logic [XLEN-1:0] w_target;
    logic [CW-1:0]   w_count;
    logic            w_credit;
    logic            w_fire;
    logic            w_rsp_ok;
    logic            w_rsp_keep;
    logic            w_head_valid;
    logic            w_head_ok;
    logic            w_load;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Low address bits are never meaningful for 32-bit instructions
    assign w_target = PCTargetE & ~XLEN'(3);

    // A request may issue only if every in-flight response is sure of a slot
    assign w_credit     = ({1'b0, r_out} + {1'b0, w_count}) < (CW + 1)'(DEPTH);
    assign ImemReqValid = ~reset & ~StallF & ~PCSrcE & w_credit;
    assign ImemAddr     = r_pcf;
    assign w_fire       = ImemReqValid & ImemReqReady;

    // Responses with nothing outstanding are ignored; stale ones are dropped
    assign w_rsp_ok   = ImemRspValid & (r_out != '0);
    assign w_rsp_keep = w_rsp_ok & (r_drop == '0) & ~PCSrcE;

    assign w_push_entry = '{pc: r_shadow[r_sh_rd], instr: ImemRspData};

    // During a redirect the head is wrong-path, so decode sees a bubble
    assign w_head_ok = w_head_valid & ~PCSrcE;
    assign w_load    = ~reset & ~FlushD & ~StallD & w_head_ok;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_rsp_keep),
        .i_push_data  (w_push_entry),
        .i_pop        (w_load),
        .i_clear      (PCSrcE),
        .o_count      (w_count),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head)
    );

    // Program counter: reset, redirect, or advance on each accepted request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcf <= RESET_PC & ~XLEN'(3);
        end else if (PCSrcE) begin
            r_pcf <= w_target;
        end else if (w_fire) begin
            r_pcf <= r_pcf + XLEN'(4);
        end
    end

    // Outstanding-request credit and count of responses still to be discarded
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out  <= '0;
            r_drop <= '0;
        end else begin
            r_out <= r_out + CW'(w_fire) - CW'(w_rsp_ok);
            if (PCSrcE) begin
                r_drop <= r_out - CW'(w_rsp_ok);
            end else if (w_rsp_ok && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
        end
    end

    // Shadow-queue pointers pairing each response with its request PC
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_wr <= '0;
            r_sh_rd <= '0;
        end else begin
            if (w_fire)   r_sh_wr <= ptr_inc(r_sh_wr);
            if (w_rsp_ok) r_sh_rd <= ptr_inc(r_sh_rd);
        end
    end

    // Shadow-queue storage of request PCs
    always_ff @(posedge clk) begin
        if (w_fire) r_shadow[r_sh_wr] <= r_pcf;
    end

    // IF/ID register: flush > stall > load head > bubble
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP;
            PCD      <= '0;
            PCPlus4D <= XLEN'(4);
        end else if (!StallD) begin
            if (w_head_ok) begin
                ValidD   <= 1'b1;
                InstrD   <= w_head.instr;
                PCD      <= w_head.pc;
                PCPlus4D <= w_head.pc + XLEN'(4);
            end else begin
                ValidD   <= 1'b0;
                InstrD   <= NOP;
                PCD      <= '0;
                PCPlus4D <= XLEN'(4);
            end
        end
    end

    // A response can only answer a request that is actually outstanding
    a_rsp_has_credit: assert property (@(posedge clk) disable iff (reset)
        ImemRspValid |-> (r_out != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by randomized
// control traffic against a stream-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TB_NOP      = 32'h0000_0013;
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReqValid, ImemReqReady;
    logic [31:0] ImemAddr;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN       (32),
        .RESET_PC   (TB_RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .PCSrcE       (PCSrcE),
        .PCTargetE    (PCTargetE),
        .ImemReqValid (ImemReqValid),
        .ImemReqReady (ImemReqReady),
        .ImemAddr     (ImemAddr),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .InstrD       (InstrD),
        .PCD          (PCD),
        .PCPlus4D     (PCPlus4D),
        .ValidD       (ValidD)
    );

    typedef struct {
        logic [31:0] pc;
        int          due;
    } req_t;

    req_t        pend[$];
    int          lat = 1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          valid_cnt = 0;
    logic        want_req = 1'b0;
    logic        want_noreq = 1'b0;
    logic [31:0] exp_dec;
    logic [31:0] exp_req;
    logic [31:0] s_instr, s_pc, s_p4;
    logic        s_valid;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive controls and memory, observe the request, then
    // check the IF/ID register against the expected instruction stream.
    task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                        input logic ps, input logic [31:0] tgt, input logic rdy);
        int nb;
        reset        = rst;
        StallF       = sf;
        StallD       = sd;
        FlushD       = fd;
        PCSrcE       = ps;
        PCTargetE    = tgt;
        ImemReqReady = rdy;
        nb = pend.size();
        if (rst) begin
            pend.delete();
            ImemRspValid = 1'b0;
            ImemRspData  = 32'h0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            ImemRspValid = 1'b1;
            ImemRspData  = instr_of(pend[0].pc);
            void'(pend.pop_front());
        end else begin
            ImemRspValid = 1'b0;
            ImemRspData  = $urandom;
        end
        #1;
        if (rst || sf || ps) check_eq("req_blocked", {31'b0, ImemReqValid}, 32'd0);
        if (want_req) begin
            check_eq("req_issue", {31'b0, ImemReqValid}, 32'd1);
            want_req = 1'b0;
        end
        if (want_noreq) begin
            check_eq("req_credit_stop", {31'b0, ImemReqValid}, 32'd0);
            want_noreq = 1'b0;
        end
        if (ImemReqValid && ImemReqReady) begin
            check_eq("req_addr", ImemAddr, exp_req);
            check_eq("req_in_flight_limit", (nb < DEPTH) ? 32'd1 : 32'd0, 32'd1);
            pend.push_back('{pc: ImemAddr, due: cyc + lat});
            exp_req = exp_req + 32'd4;
        end
        if (rst) begin
            exp_req = TB_RESET_PC;
            exp_dec = TB_RESET_PC;
        end else if (ps) begin
            exp_req = tgt & ~32'd3;
            exp_dec = tgt & ~32'd3;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            check_eq("rst_valid", {31'b0, ValidD}, 32'd0);
            check_eq("rst_instr", InstrD, TB_NOP);
            check_eq("rst_pcd", PCD, 32'd0);
            check_eq("rst_pcplus4", PCPlus4D, 32'd4);
            check_eq("rst_addr", ImemAddr, TB_RESET_PC);
        end else if (fd) begin
            check_eq("flush_valid", {31'b0, ValidD}, 32'd0);
            check_eq("flush_instr", InstrD, TB_NOP);
        end else if (sd) begin
            check_eq("stall_valid", {31'b0, ValidD}, {31'b0, s_valid});
            check_eq("stall_instr", InstrD, s_instr);
            check_eq("stall_pcd", PCD, s_pc);
            check_eq("stall_pcplus4", PCPlus4D, s_p4);
        end else if (ValidD) begin
            check_eq("stream_pcd", PCD, exp_dec);
            check_eq("stream_instr", InstrD, instr_of(exp_dec));
            check_eq("stream_pcplus4", PCPlus4D, exp_dec + 32'd4);
            exp_dec = exp_dec + 32'd4;
            valid_cnt++;
        end
        s_valid = ValidD;
        s_instr = InstrD;
        s_pc    = PCD;
        s_p4    = PCPlus4D;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = 32'h0; ImemReqReady = 1'b1; ImemRspValid = 1'b0; ImemRspData = 32'h0;
        exp_dec = TB_RESET_PC;
        exp_req = TB_RESET_PC;
        s_valid = 1'b0; s_instr = TB_NOP; s_pc = 32'h0; s_p4 = 32'h4;

        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // First request right after reset, first instruction two cycles later
        want_req = 1'b1;
        run(1);
        check_eq("first_cycle1_bubble", {31'b0, ValidD}, 32'd0);
        run(1);
        check_eq("first_cycle2_valid", {31'b0, ValidD}, 32'd1);
        check_eq("first_pcd", PCD, TB_RESET_PC);

        // Sustained throughput with single-cycle memory
        valid_cnt = 0;
        run(8);
        check_eq("throughput", valid_cnt, (DEPTH > 1) ? 32'd8 : 32'd4);

        // Decode stall for three cycles; issue stops once the queue is full
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        want_noreq = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        run(6);

        // Redirect with three-cycle memory and requests in flight
        lat = 3;
        run(6);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1);
        begin
            int n;
            n = 0;
            while (!ValidD && n < 20) begin
                run(1);
                n++;
            end
            check_eq("redirect_seen", {31'b0, ValidD}, 32'd1);
            check_eq("redirect_first_pcd", PCD, 32'h0000_0100);
        end

        // Redirect + flush while fetch is stalled
        lat = 1;
        run(10);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0243, 1'b1);
        check_eq("combo_pcf", ImemAddr, 32'h0000_0240);
        check_eq("combo_valid", {31'b0, ValidD}, 32'd0);
        want_req = 1'b1;
        run(6);

        // Reset in the middle of a stream with a full queue
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        want_req = 1'b1;
        run(6);
        check_eq("restart_valid", {31'b0, ValidD}, 32'd1);

        // Randomized control traffic
        for (int i = 0; i < 1500; i++) begin
            logic        r_rst, r_ps;
            logic [31:0] r_tgt;
            if (i % 100 == 0) lat = $urandom_range(1, 3);
            r_rst = ($urandom_range(0, 99) < 1);
            r_ps  = ($urandom_range(0, 99) < 5);
            r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(r_rst, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 5, r_ps, r_tgt, $urandom_range(0, 99) < 80);
        end
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
